// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: req/ready front end, SETUP/ACCESS/TURN bus cycle, tri-state data port.
// Optional acknowledge/timeout handling is compiled in when DMEM_ACK_EN is defined.
module dmem_bus_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mcu_req,
  output logic              mcu_ready,
  input  logic              mcu_write,
  input  logic              mcu_addr_sel,
  input  logic [ADDR_W-1:0] mcu_addr_imm,
  input  logic [ADDR_W-1:0] mcu_addr_reg,
  input  logic [DATA_W-1:0] mcu_wdata,
  output logic [DATA_W-1:0] mcu_rdata,
  output logic              mcu_done,
  output logic              dmem_cs,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  inout  wire  [DATA_W-1:0] dmem_data
`ifdef DMEM_ACK_EN
  ,
  input  logic              dmem_ack,
  output logic              mcu_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_TURN
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || ACK_TIMEOUT < 1) begin : g_param_check
    $error("dmem_bus_ctrl: WAIT_CYCLES must be 0..15 and ACK_TIMEOUT at least 1");
  end

  state_t            state;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              dmem_oe;
  logic [3:0]        wait_cnt;

`ifdef DMEM_ACK_EN
  localparam int ACC_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACK_TIMEOUT - 1);
  logic [ACC_W-1:0]  acc_cnt;
`endif

  // The port is only driven while a write owns the bus; IDLE and TURN always release it.
  assign dmem_data = dmem_oe ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      mcu_ready <= 1'b1;
      mcu_done  <= 1'b0;
      mcu_rdata <= '0;
      dmem_cs   <= 1'b0;
      dmem_we   <= 1'b0;
      dmem_addr <= '0;
      dmem_oe   <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
`ifdef DMEM_ACK_EN
      acc_cnt   <= '0;
      mcu_err   <= 1'b0;
`endif
    end else begin
      mcu_done <= 1'b0;
`ifdef DMEM_ACK_EN
      mcu_err  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (mcu_req) begin
            state     <= S_SETUP;
            mcu_ready <= 1'b0;
            write_q   <= mcu_write;
            wdata_q   <= mcu_wdata;
            dmem_addr <= mcu_addr_sel ? mcu_addr_reg : mcu_addr_imm;
            dmem_cs   <= 1'b1;
            dmem_we   <= mcu_write;
            dmem_oe   <= mcu_write;
          end
        end

        S_SETUP: begin
          state    <= S_ACCESS;
          wait_cnt <= WAIT_LOAD;
`ifdef DMEM_ACK_EN
          acc_cnt  <= '0;
`endif
        end

        S_ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
`ifdef DMEM_ACK_EN
          // The wait count is the minimum access time; the ack then closes the access.
          if (wait_cnt == 4'd0 && dmem_ack) begin
            state    <= S_TURN;
            mcu_done <= 1'b1;
            dmem_cs  <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_oe  <= 1'b0;
            if (!write_q) begin
              mcu_rdata <= dmem_data;
            end
          end else if (acc_cnt == ACC_LAST) begin
            state    <= S_TURN;
            mcu_done <= 1'b1;
            mcu_err  <= 1'b1;
            dmem_cs  <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_oe  <= 1'b0;
          end else begin
            acc_cnt <= acc_cnt + 1'b1;
          end
`else
          if (wait_cnt == 4'd0) begin
            state    <= S_TURN;
            mcu_done <= 1'b1;
            dmem_cs  <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_oe  <= 1'b0;
            if (!write_q) begin
              mcu_rdata <= dmem_data;
            end
          end
`endif
        end

        S_TURN: begin
          state     <= S_IDLE;
          mcu_ready <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          mcu_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: vector table, hand-written corner sequences and
// random accesses checked against a word-level memory/timing model. Pull-up bus: released reads 0xFF.
module tb_dmem_bus_ctrl;

  localparam int W   = 2;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mcu_req = 1'b0;
  logic       mcu_write = 1'b0;
  logic       mcu_addr_sel = 1'b0;
  logic [7:0] mcu_addr_imm = 8'h00;
  logic [7:0] mcu_addr_reg = 8'h00;
  logic [7:0] mcu_wdata = 8'h00;
  logic       mcu_ready;
  logic       mcu_done;
  logic       dmem_cs;
  logic       dmem_we;
  logic [7:0] mcu_rdata;
  logic [7:0] dmem_addr;
  tri1  [7:0] dmem_data;
`ifdef DMEM_ACK_EN
  logic       dmem_ack = 1'b1;
  logic       mcu_err;
`endif

  int checks = 0;
  int errors = 0;

  // Memory device attached to the bus, plus the bench's own expectation of its contents.
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  bit         written [256];
  logic [7:0] waddrs [$];
  logic [7:0] model_rdata = 8'h00;

  typedef struct {
    logic       wr;
    logic       sel;
    logic [7:0] imm;
    logic [7:0] rg;
    logic [7:0] wd;
    logic [7:0] exp_addr;
    logic [7:0] exp_rd;
  } vec_t;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dmem_cs && dmem_we) mem[dmem_addr] <= dmem_data;
  end
  assign dmem_data = (dmem_cs && !dmem_we) ? mem[dmem_addr] : 8'hzz;

  dmem_bus_ctrl #(
    .DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(W), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .mcu_req(mcu_req), .mcu_ready(mcu_ready), .mcu_write(mcu_write),
    .mcu_addr_sel(mcu_addr_sel), .mcu_addr_imm(mcu_addr_imm), .mcu_addr_reg(mcu_addr_reg),
    .mcu_wdata(mcu_wdata), .mcu_rdata(mcu_rdata), .mcu_done(mcu_done),
    .dmem_cs(dmem_cs), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_data(dmem_data)
`ifdef DMEM_ACK_EN
    , .dmem_ack(dmem_ack), .mcu_err(mcu_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!mcu_ready && n < 20) begin
      tick();
      n++;
    end
    chk1({tag, "_ready_wait"}, mcu_ready, 1'b1);
  endtask

  task automatic note_write(input logic [7:0] a, input logic [7:0] d);
    ref_mem[a] = d;
    if (!written[a]) begin
      written[a] = 1'b1;
      waddrs.push_back(a);
    end
  endtask

  // Issue one request and return one cycle after the acceptance edge, with req dropped.
  task automatic start(input logic wr, input logic sel, input logic [7:0] imm,
                       input logic [7:0] rg, input logic [7:0] wd, input string tag);
    wait_ready(tag);
    mcu_req = 1'b1; mcu_write = wr; mcu_addr_sel = sel;
    mcu_addr_imm = imm; mcu_addr_reg = rg; mcu_wdata = wd;
    tick();
    mcu_req = 1'b0;
  endtask

  // Full single access with cycle-exact expectations: bus owned for W+2 cycles, done on the next.
  task automatic run_access(input vec_t v, input string tag);
    logic [7:0] exp_rd;
    exp_rd = v.wr ? model_rdata : v.exp_rd;
    start(v.wr, v.sel, v.imm, v.rg, v.wd, tag);
    chk1({tag, "_ready_busy"}, mcu_ready, 1'b0);
    // Inputs are scrambled while busy; the transfer must not notice.
    mcu_write = ~v.wr; mcu_addr_sel = ~v.sel; mcu_addr_imm = ~v.imm;
    mcu_addr_reg = ~v.rg; mcu_wdata = ~v.wd;
    for (int k = 0; k <= W + 1; k++) begin
      chk1({tag, "_cs"}, dmem_cs, 1'b1);
      chk1({tag, "_we"}, dmem_we, v.wr);
      chk8({tag, "_addr"}, dmem_addr, v.exp_addr);
      chk1({tag, "_done_early"}, mcu_done, 1'b0);
      if (v.wr) chk8({tag, "_bus_wdata"}, dmem_data, v.wd);
      tick();
    end
    chk1({tag, "_done"}, mcu_done, 1'b1);
    chk1({tag, "_cs_turn"}, dmem_cs, 1'b0);
    chk1({tag, "_we_turn"}, dmem_we, 1'b0);
    chk8({tag, "_bus_z_turn"}, dmem_data, 8'hFF);
    chk8({tag, "_rdata"}, mcu_rdata, exp_rd);
`ifdef DMEM_ACK_EN
    chk1({tag, "_err"}, mcu_err, 1'b0);
`endif
    tick();
    chk1({tag, "_done_clear"}, mcu_done, 1'b0);
    chk1({tag, "_ready_back"}, mcu_ready, 1'b1);
    if (v.wr) note_write(v.exp_addr, v.wd);
    else model_rdata = exp_rd;
    $display("txn %s wr=%0b addr=%02h wdata=%02h rdata=%02h exp_rdata=%02h",
             tag, v.wr, v.exp_addr, v.wd, mcu_rdata, exp_rd);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs [8];
    vec_t v;
    logic [7:0] a;
    int n;
    int dones;
    int done_k;

    vecs[0] = '{1'b1, 1'b0, 8'h3C, 8'h77, 8'hA5, 8'h3C, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 8'h12, 8'h81, 8'h5A, 8'h81, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h81, 8'h00, 8'h81, 8'h5A};
    vecs[3] = '{1'b0, 1'b0, 8'h3C, 8'h81, 8'h00, 8'h3C, 8'hA5};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{1'b1, 1'b1, 8'h00, 8'hFE, 8'h7E, 8'hFE, 8'h00};
    vecs[7] = '{1'b0, 1'b1, 8'h3C, 8'hFE, 8'h00, 8'hFE, 8'h7E};

    // Reset values
    #12;
    chk1("rst_ready", mcu_ready, 1'b1);
    chk1("rst_done", mcu_done, 1'b0);
    chk8("rst_rdata", mcu_rdata, 8'h00);
    chk1("rst_cs", dmem_cs, 1'b0);
    chk1("rst_we", dmem_we, 1'b0);
    chk8("rst_addr", dmem_addr, 8'h00);
    chk8("rst_bus_z", dmem_data, 8'hFF);
`ifdef DMEM_ACK_EN
    chk1("rst_err", mcu_err, 1'b0);
`endif
    rst = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i], $sformatf("vec%0d", i));
    end

    // Request held high: write 0x11 to 0x10, then a read of 0x10 issued back to back.
    wait_ready("b2b");
    mcu_req = 1'b1; mcu_write = 1'b1; mcu_addr_sel = 1'b0;
    mcu_addr_imm = 8'h10; mcu_wdata = 8'h11;
    tick();
    mcu_write = 1'b0; mcu_wdata = 8'h99;
    n = 0;
    while (!mcu_done && n < 20) begin tick(); n++; end
    chk1("b2b_first_done", mcu_done, 1'b1);
    chk8("b2b_bus_z_between", dmem_data, 8'hFF);
    n = 0;
    while (!(dmem_cs && !dmem_we) && n < 20) begin tick(); n++; end
    mcu_req = 1'b0;
    chk1("b2b_read_started", dmem_cs && !dmem_we, 1'b1);
    chk8("b2b_read_addr", dmem_addr, 8'h10);
    n = 0;
    while (!mcu_done && n < 20) begin tick(); n++; end
    chk1("b2b_second_done", mcu_done, 1'b1);
    chk8("b2b_rdata", mcu_rdata, 8'h11);
    note_write(8'h10, 8'h11);
    model_rdata = 8'h11;
    $display("txn b2b write 10<=11 then read 10 rdata=%02h", mcu_rdata);
    tick();

    // Inputs churned and req toggled while busy: exactly one completion, bus untouched.
    start(1'b1, 1'b0, 8'h20, 8'h00, 8'h33, "busy");
    dones = 0;
    for (int k = 0; k <= W + 6; k++) begin
      if (k <= W + 1) begin
        chk8("busy_addr", dmem_addr, 8'h20);
        chk1("busy_we", dmem_we, 1'b1);
        chk8("busy_bus", dmem_data, 8'h33);
        mcu_req = 1'($urandom_range(0, 1));
        mcu_write = 1'($urandom_range(0, 1));
        mcu_addr_imm = 8'($urandom);
        mcu_wdata = 8'($urandom);
      end else begin
        mcu_req = 1'b0;
      end
      if (k == W + 1) mcu_req = 1'b0;
      if (mcu_done) dones++;
      tick();
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL busy_done_count: got %0d pulses, expected 1", dones);
    end
    chk1("busy_idle_cs", dmem_cs, 1'b0);
    note_write(8'h20, 8'h33);
    $display("txn busy write 20<=33 done_pulses=%0d", dones);

    // Random accesses against the model
    for (int i = 0; i < 40; i++) begin
      v.wr  = (waddrs.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      v.sel = 1'($urandom_range(0, 1));
      v.imm = 8'($urandom);
      v.rg  = 8'($urandom);
      v.wd  = 8'($urandom_range(0, 254));
      if (!v.wr) begin
        a = waddrs[$urandom_range(0, waddrs.size() - 1)];
        if (v.sel) v.rg = a;
        else v.imm = a;
      end
      v.exp_addr = v.sel ? v.rg : v.imm;
      v.exp_rd   = v.wr ? 8'h00 : ref_mem[v.exp_addr];
      run_access(v, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a write's ACCESS phase
    v = '{1'b1, 1'b0, 8'h70, 8'h00, 8'h6B, 8'h70, 8'h00};
    run_access(v, "pre_rst_wr");
    v = '{1'b0, 1'b0, 8'h70, 8'h00, 8'h00, 8'h70, 8'h6B};
    run_access(v, "pre_rst_rd");
    start(1'b1, 1'b0, 8'h55, 8'h00, 8'h3D, "midrst");
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk1("midrst_cs", dmem_cs, 1'b0);
    chk1("midrst_we", dmem_we, 1'b0);
    chk8("midrst_bus_z", dmem_data, 8'hFF);
    chk8("midrst_rdata", mcu_rdata, 8'h00);
    chk1("midrst_ready", mcu_ready, 1'b1);
    chk1("midrst_done", mcu_done, 1'b0);
    chk8("midrst_addr", dmem_addr, 8'h00);
    tick();
    rst = 1'b1;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (mcu_done) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midrst_no_done: got %0d pulses, expected 0", dones);
    end
    chk1("midrst_idle_cs", dmem_cs, 1'b0);
    note_write(8'h55, 8'h3D);
    model_rdata = 8'h00;
    $display("txn midrst write 55 aborted rdata=%02h", mcu_rdata);
    v = '{1'b0, 1'b1, 8'h00, 8'h10, 8'h00, 8'h10, 8'h11};
    run_access(v, "post_rst_rd");

`ifdef DMEM_ACK_EN
    v = '{1'b1, 1'b0, 8'h44, 8'h00, 8'hC7, 8'h44, 8'h00};
    run_access(v, "ack_wr44");
    v = '{1'b1, 1'b0, 8'h45, 8'h00, 8'h18, 8'h45, 8'h00};
    run_access(v, "ack_wr45");

    // Ack raised in the fifth ACCESS cycle: completion on the following edge.
    dmem_ack = 1'b0;
    start(1'b0, 1'b0, 8'h44, 8'h00, 8'h00, "ack_late");
    done_k = -1;
    for (int k = 0; k < 20 && done_k < 0; k++) begin
      if (mcu_done) done_k = k;
      else begin
        if (k == 5) dmem_ack = 1'b1;
        tick();
      end
    end
    checks++;
    if (done_k != 6) begin
      errors++;
      $display("FAIL ack_late_latency: done after %0d cycles, expected 6", done_k);
    end
    chk1("ack_late_err", mcu_err, 1'b0);
    chk8("ack_late_rdata", mcu_rdata, 8'hC7);
    model_rdata = 8'hC7;
    $display("txn ack_late read 44 done_k=%0d rdata=%02h", done_k, mcu_rdata);
    tick();

    // No ack at all: timeout after TMO ACCESS cycles, rdata held.
    dmem_ack = 1'b0;
    start(1'b0, 1'b0, 8'h45, 8'h00, 8'h00, "ack_tmo");
    done_k = -1;
    for (int k = 0; k < 30 && done_k < 0; k++) begin
      if (mcu_done) done_k = k;
      else tick();
    end
    checks++;
    if (done_k != TMO + 1) begin
      errors++;
      $display("FAIL ack_tmo_latency: done after %0d cycles, expected %0d", done_k, TMO + 1);
    end
    chk1("ack_tmo_err", mcu_err, 1'b1);
    chk8("ack_tmo_rdata", mcu_rdata, 8'hC7);
    chk8("ack_tmo_bus_z", dmem_data, 8'hFF);
    tick();
    chk1("ack_tmo_err_clear", mcu_err, 1'b0);
    chk1("ack_tmo_done_clear", mcu_done, 1'b0);
    chk1("ack_tmo_ready", mcu_ready, 1'b1);
    $display("txn ack_tmo read 45 done_k=%0d rdata=%02h", done_k, mcu_rdata);
    dmem_ack = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
